push_pop_sequencer: RTL and testbench
=====================================

PUSH_POP_SEQUENCER -- requirements
Module: push_pop_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning memory byte-address width.
REQ-002 SHALL have ports clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have start  in  1  one-cycle request to begin a PUSH or POP, sampled only in IDLE.
REQ-004 SHALL have op  in  1  0 = PUSH, 1 = POP, captured with start.
REQ-005 SHALL have reg_list  in  8  low-register mask r0..r7, captured with start.
REQ-006 SHALL have extra  in  1  PUSH: include lr (select 4'he); POP: load PC.
REQ-007 SHALL have sp_value  in  32  current SP, captured with start.
REQ-008 SHALL have rf_rd_select  out  4  register-file read select; rf_rdata  in  32  read data, valid one cycle after select.
REQ-009 SHALL have rf_wr_en  out  1; rf_wr_select  out  4; rf_wr_data  out  32  register-file write port.
REQ-010 SHALL have rf_sp_write_en  out  1; rf_sp_out  out  32  SP update port.
REQ-011 SHALL have mem_req  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  32; mem_ready  in  1; mem_rdata  in  32.
REQ-012 SHALL have pc_load  out  1; pc_out  out  32  branch on POP with extra.
REQ-013 SHALL have busy  out  1; done  out  1.

Function
REQ-014 SHALL implement states IDLE, RD, RWAIT, MEM, WB, SPUPD, DONE.
REQ-015 SHALL set N = popcount(reg_list) + extra (range 0..9) on start; base = sp_value - 4*N for PUSH, sp_value for POP.
REQ-016 SHALL process registers in ascending order r0..r7, then the extra slot, at addresses base, base+4, ... (lowest register at lowest address).
REQ-017 PUSH per slot: RD drives rf_rd_select = register for one cycle; RWAIT latches rf_rdata; MEM drives mem_req=1, mem_we=1, mem_addr, mem_wdata until mem_ready is sampled high.
REQ-018 POP per slot: MEM drives mem_req=1, mem_we=0 until mem_ready, capturing mem_rdata that cycle; WB pulses rf_wr_en one cycle with rf_wr_select = register, rf_wr_data = captured value.
REQ-019 POP extra slot SHALL NOT use rf_wr_en; instead it SHALL pulse pc_load one cycle in WB with pc_out = captured value & 32'hFFFF_FFFE.
REQ-020 After the last slot, SPUPD SHALL pulse rf_sp_write_en one cycle with rf_sp_out = sp_value - 4*N (PUSH) or sp_value + 4*N (POP), modulo 2^32.
REQ-021 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-023 If N = 0, start SHALL go IDLE -> DONE directly, with no memory access and no SP write.
REQ-024 mem_req, mem_addr, mem_we and mem_wdata SHALL remain stable while mem_req=1 and mem_ready=0; there SHALL be no timeout.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W without error.
REQ-026 rf_wr_en, rf_sp_write_en and pc_load SHALL never be asserted in the same cycle.

Reset
REQ-027 On rst, state SHALL be IDLE; busy, done, mem_req, mem_we, rf_wr_en, rf_sp_write_en and pc_load SHALL be 0; rf_rd_select, rf_wr_select, mem_addr, mem_wdata, rf_wr_data, rf_sp_out and pc_out SHALL be 0.
REQ-028 rst mid-operation SHALL abort immediately: no further memory access, no SP write, and no done pulse.

Verification
REQ-029 PUSH reg_list=8'h05, extra=1, sp=0x1000, mem_ready=1 -> writes r0@0xFF4, r2@0xFF8, lr@0xFFC; rf_sp_out=0xFF4; single done pulse.
REQ-030 POP reg_list=8'h81, extra=1, sp=0xFF4, mem_rdata 0x11, 0x77, 0x2001 -> r0=0x11, r7=0x77, pc_load with pc_out=0x2000, rf_sp_out=0x1000.
REQ-031 PUSH reg_list=8'h00, extra=0 -> done two cycles after start; no mem_req, no rf_sp_write_en.
REQ-032 POP of one register with mem_ready held low 5 cycles -> mem_addr stable throughout; exactly one rf_wr_en after mem_ready rises.
REQ-033 rst asserted during the second MEM of a 3-register PUSH -> next cycle all outputs 0, busy=0, no rf_sp_write_en ever seen.
REQ-034 start pulsed while busy, and PUSH with sp=0x4, N=2 -> second start ignored; rf_sp_out=0xFFFF_FFFC, first address 0xFFFF_FFFC.

Source files
------------

// File: rtl/push_pop_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : push_pop_sequencer_if
// Brief    : Memory request/response bus between the PUSH/POP sequencer and
//            its data memory.
// Revision : 1.0
// ============================================================================
interface push_pop_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/push_pop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : push_pop_sequencer
// Brief    : Multi-register PUSH/POP engine: walks a register mask, moves each
//            slot between register file and memory, then updates SP.
// Revision : 1.0
// ============================================================================
module push_pop_sequencer #(
  parameter int ADDR_W = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  input  wire logic        op,
  input  wire logic [7:0]  reg_list,
  input  wire logic        extra,
  input  wire logic [31:0] sp_value,
  output logic [3:0]       rf_rd_select,
  input  wire logic [31:0] rf_rdata,
  output logic             rf_wr_en,
  output logic [3:0]       rf_wr_select,
  output logic [31:0]      rf_wr_data,
  output logic             rf_sp_write_en,
  output logic [31:0]      rf_sp_out,
  push_pop_sequencer_if.master mem,
  output logic             pc_load,
  output logic [31:0]      pc_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_SPUPD = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [3:0] c_LR_SEL = 4'he;

  state_t            r_state;
  state_t            w_next;
  logic              r_op;
  logic [8:0]        r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [31:0]       r_sp_new;

  logic [3:0]        w_cnt;
  logic [31:0]       w_four_n;
  logic [31:0]       w_sp_new;
  logic [31:0]       w_base;
  logic [3:0]        w_slot;
  logic [8:0]        w_mask_next;
  logic              w_is_extra;
  logic [3:0]        w_reg_sel;

  // Slot count and address window, computed from the live inputs at start.
  always_comb begin
    w_cnt = 4'(extra);
    for (int i = 0; i < 8; i++) begin
      w_cnt = w_cnt + 4'(reg_list[i]);
    end
  end

  assign w_four_n = {26'd0, w_cnt, 2'b00};
  assign w_sp_new = op ? (sp_value + w_four_n) : (sp_value - w_four_n);
  assign w_base   = op ? sp_value : w_sp_new;

  // Bit 8 of the mask is the extra slot, so it is naturally served last.
  always_comb begin
    w_slot = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_slot = 4'(i);
      end
    end
  end

  assign w_mask_next = r_mask & (r_mask - 9'd1);
  assign w_is_extra  = w_slot[3];
  assign w_reg_sel   = w_is_extra ? c_LR_SEL : {1'b0, w_slot[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 1'b0;
      r_mask   <= 9'd0;
      r_addr   <= '0;
      r_data   <= 32'd0;
      r_sp_new <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_op     <= op;
        r_mask   <= {extra, reg_list};
        r_addr   <= ADDR_W'(w_base);
        r_sp_new <= w_sp_new;
      end
      if (r_state == S_RWAIT) begin
        r_data <= rf_rdata;
      end
      if (r_state == S_MEM && mem.mem_ready) begin
        if (r_op) begin
          r_data <= mem.mem_rdata;
        end else begin
          r_mask <= w_mask_next;
          r_addr <= r_addr + ADDR_W'(4);
        end
      end
      if (r_state == S_WB) begin
        r_mask <= w_mask_next;
        r_addr <= r_addr + ADDR_W'(4);
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    busy           = (r_state != S_IDLE);
    done           = 1'b0;
    rf_rd_select   = 4'd0;
    rf_wr_en       = 1'b0;
    rf_wr_select   = 4'd0;
    rf_wr_data     = 32'd0;
    rf_sp_write_en = 1'b0;
    rf_sp_out      = 32'd0;
    pc_load        = 1'b0;
    pc_out         = 32'd0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = 32'd0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cnt == 4'd0) begin
            w_next = S_DONE;
          end else begin
            w_next = op ? S_MEM : S_RD;
          end
        end
      end
      S_RD: begin
        rf_rd_select = w_reg_sel;
        w_next       = S_RWAIT;
      end
      S_RWAIT: begin
        w_next = S_MEM;
      end
      S_MEM: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = ~r_op;
        mem.mem_addr  = r_addr;
        mem.mem_wdata = r_op ? 32'd0 : r_data;
        if (mem.mem_ready) begin
          if (r_op) begin
            w_next = S_WB;
          end else begin
            w_next = (w_mask_next == 9'd0) ? S_SPUPD : S_RD;
          end
        end
      end
      S_WB: begin
        if (w_is_extra) begin
          pc_load = 1'b1;
          pc_out  = r_data & 32'hFFFF_FFFE;
        end else begin
          rf_wr_en     = 1'b1;
          rf_wr_select = w_reg_sel;
          rf_wr_data   = r_data;
        end
        w_next = (w_mask_next == 9'd0) ? S_SPUPD : S_MEM;
      end
      S_SPUPD: begin
        rf_sp_write_en = 1'b1;
        rf_sp_out      = r_sp_new;
        w_next         = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_push_pop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_push_pop_sequencer
// Brief    : Scoreboard bench: a slot-list model queues expected bus events,
//            a monitor pops and compares them as the DUT produces them.
// Revision : 1.0
// ============================================================================
module tb_push_pop_sequencer;

  localparam int K_MEMW = 1;
  localparam int K_MEMR = 2;
  localparam int K_RFW  = 3;
  localparam int K_PC   = 4;
  localparam int K_SP   = 5;
  localparam int K_DONE = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [7:0]  reg_list = 8'd0;
  logic        extra = 1'b0;
  logic [31:0] sp_value = 32'd0;
  logic [3:0]  rf_rd_select;
  logic [31:0] rf_rdata = 32'd0;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_select;
  logic [31:0] rf_wr_data;
  logic        rf_sp_write_en;
  logic [31:0] rf_sp_out;
  logic        pc_load;
  logic [31:0] pc_out;
  logic        busy;
  logic        done;

  push_pop_sequencer_if #(.ADDR_W(32)) mif ();

  push_pop_sequencer #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op             (op),
    .reg_list       (reg_list),
    .extra          (extra),
    .sp_value       (sp_value),
    .rf_rd_select   (rf_rd_select),
    .rf_rdata       (rf_rdata),
    .rf_wr_en       (rf_wr_en),
    .rf_wr_select   (rf_wr_select),
    .rf_wr_data     (rf_wr_data),
    .rf_sp_write_en (rf_sp_write_en),
    .rf_sp_out      (rf_sp_out),
    .mem            (mif),
    .pc_load        (pc_load),
    .pc_out         (pc_out),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] rf_mem [16];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          hs_cnt = 0;
  int          sp_cnt = 0;
  int          fixed_lat = -1;
  int          lat_max = 2;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
  endfunction

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{k, a, d});
  endtask

  // Reference: list the slots in order, assign consecutive words from base.
  task automatic model(input bit pop, input logic [7:0] regs, input bit ext, input logic [31:0] sp);
    logic [8:0]  slots;
    int          n;
    int          k;
    logic [31:0] base;
    logic [31:0] a;
    logic [31:0] d;
    slots = {ext, regs};
    n = $countones(slots);
    k = 0;
    if (n == 0) begin
      expect_ev(K_DONE, 0, 0);
      return;
    end
    base = pop ? sp : sp - 32'(4 * n);
    for (int r = 0; r < 9; r++) begin
      if (slots[r]) begin
        a = base + 32'(4 * k);
        k++;
        if (!pop) begin
          expect_ev(K_MEMW, a, (r < 8) ? rf_mem[r] : rf_mem[14]);
        end else begin
          d = rd_val(a);
          expect_ev(K_MEMR, a, 0);
          if (r < 8) expect_ev(K_RFW, 32'(r), d);
          else       expect_ev(K_PC, 0, d & 32'hFFFF_FFFE);
        end
      end
    end
    expect_ev(K_SP, 0, pop ? sp + 32'(4 * n) : sp - 32'(4 * n));
    expect_ev(K_DONE, 0, 0);
  endtask

  task automatic got(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d a=%h d=%h, expected nothing", k, a, d);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind%0d", e.kind), {32'(k), a, d}, {32'(e.kind), e.a, e.d});
    end
  endtask

  // Register file: data for the select seen one cycle earlier.
  initial begin
    logic [3:0] sel_d;
    sel_d = 4'd0;
    forever begin
      @(negedge clk);
      rf_rdata = rf_mem[sel_d];
      sel_d    = rf_rd_select;
    end
  end

  // Memory responder with a per-access wait of 0..lat_max (or fixed_lat).
  initial begin
    int lat;
    bit waiting;
    lat = 0;
    waiting = 1'b0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst || mif.mem_ready) begin
        mif.mem_ready = 1'b0;
        mif.mem_rdata = $urandom;
        waiting = 1'b0;
      end else if (mif.mem_req) begin
        if (!waiting) begin
          waiting = 1'b1;
          lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(lat_max, 0);
        end
        if (lat == 0) begin
          mif.mem_ready = 1'b1;
          mif.mem_rdata = rd_val(mif.mem_addr);
        end else begin
          lat--;
        end
      end
    end
  end

  // Monitor
  initial begin
    bit          prev_hold;
    logic [65:0] prev_bus;
    int          n_str;
    prev_hold = 1'b0;
    prev_bus  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold)
          check("mem_hold_stable", {mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata}, prev_bus);
        if (mif.mem_req && mif.mem_ready) begin
          hs_cnt++;
          got(mif.mem_we ? K_MEMW : K_MEMR, mif.mem_addr, mif.mem_we ? mif.mem_wdata : 32'd0);
        end
        if (rf_wr_en)       got(K_RFW, 32'(rf_wr_select), rf_wr_data);
        if (pc_load)        got(K_PC, 0, pc_out);
        if (rf_sp_write_en) begin
          sp_cnt++;
          got(K_SP, 0, rf_sp_out);
        end
        if (done) begin
          done_cnt++;
          got(K_DONE, 0, 0);
        end
        n_str = int'(rf_wr_en) + int'(rf_sp_write_en) + int'(pc_load);
        if (n_str > 0) check("strobe_exclusive", 32'(n_str), 1);
        prev_hold = mif.mem_req && !mif.mem_ready;
        prev_bus  = {mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata};
      end
    end
  end

  task automatic issue(input bit pop, input logic [7:0] regs, input bit ext, input logic [31:0] sp);
    @(negedge clk);
    model(pop, regs, ext, sp);
    start = 1'b1; op = pop; reg_list = regs; extra = ext; sp_value = sp;
    @(negedge clk);
    start = 1'b0; op = $urandom; reg_list = $urandom; extra = $urandom; sp_value = $urandom;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    int d0;
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < bound) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit pop;
    logic [31:0] sp;
    for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;

    repeat (3) @(negedge clk);
    #3;
    check("reset_ctrl", {busy, done, mif.mem_req, mif.mem_we, rf_wr_en, rf_sp_write_en, pc_load}, 0);
    check("reset_sel", {rf_rd_select, rf_wr_select}, 0);
    check("reset_data", mif.mem_addr | mif.mem_wdata | rf_wr_data | rf_sp_out | pc_out, 0);
    rst = 1'b0;

    // PUSH r0,r2,lr from SP 0x1000 with an always-ready memory.
    fixed_lat = 0;
    issue(1'b0, 8'h05, 1'b1, 32'h0000_1000);
    check("busy_after_start", busy, 1);
    wait_done(100, cyc);

    // POP r0,r7,pc from 0xFF4; PC lands on a halfword boundary.
    mem_img[32'h0FF4] = 32'h11;
    mem_img[32'h0FF8] = 32'h77;
    mem_img[32'h0FFC] = 32'h2001;
    issue(1'b1, 8'h81, 1'b1, 32'h0000_0FF4);
    wait_done(100, cyc);

    // Empty list: straight to DONE.
    issue(1'b0, 8'h00, 1'b0, 32'h0000_2000);
    wait_done(10, cyc);
    check("n0_done_latency", 32'(cyc <= 2), 1);

    // POP of one register against a slow memory.
    fixed_lat = 5;
    issue(1'b1, 8'h10, 1'b0, 32'h0000_0400);
    wait_done(100, cyc);

    // PUSH with SP near zero wraps the window; a start while busy is ignored.
    fixed_lat = 1;
    issue(1'b0, 8'h03, 1'b0, 32'h0000_0004);
    @(negedge clk);
    #1;
    check("busy_mid_op", busy, 1);
    start = 1'b1; op = 1'b1; reg_list = 8'hFF; extra = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, cyc);
    repeat (12) @(negedge clk);
    #3;
    check("busy_start_ignored", {busy, 32'(done_cnt)}, {1'b0, 32'(5)});

    // Abort a 3-register PUSH during its second memory access.
    fixed_lat = 4;
    issue(1'b0, 8'h07, 1'b0, 32'h0000_8000);
    begin
      int h0;
      int t;
      int d0;
      int s0;
      h0 = hs_cnt;
      t = 0;
      while ((hs_cnt == h0 || !mif.mem_req) && t < 60) begin
        @(negedge clk);
        #3;
        t++;
      end
      check("abort_reached_mem2", 32'(hs_cnt - h0), 1);
      d0 = done_cnt;
      s0 = sp_cnt;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      #3;
      check("abort_ctrl", {busy, done, mif.mem_req, mif.mem_we, rf_wr_en, rf_sp_write_en, pc_load}, 0);
      check("abort_data", mif.mem_addr | mif.mem_wdata | rf_wr_data | rf_sp_out | pc_out, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #3;
      check("abort_no_sp_no_done", {32'(sp_cnt - s0), 32'(done_cnt - d0)}, 0);
    end

    // Randomized operations against the slot model.
    fixed_lat = -1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
      lat_max = $urandom_range(3, 0);
      pop = 1'($urandom);
      case ($urandom_range(3, 0))
        0:       sp = 32'($urandom_range(12, 0)) << 2;
        1:       sp = 32'hFFFF_FFF0 + (32'($urandom_range(3, 0)) << 2);
        default: sp = $urandom & 32'hFFFF_FFFC;
      endcase
      issue(pop, 8'($urandom), 1'($urandom), sp);
      wait_done(400, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
